// File: rtl/fifo_param.sv
// fifo_param -- parameterised synchronous FIFO.
//
// Generic buffering primitive between pipeline stages and in issue/retire
// queues. Register-array storage of 2**ENTRIES_POW2 words, occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush, standard or
// first-word-fall-through read, write-through when full, and sticky
// overflow/underflow error flags.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset
//   flush_i        synchronous clear of contents and error flags
//   write_i        write request, data on write_data_i
//   read_i         read request (pop/acknowledge in FWFT mode)
//   read_data_o    read data
//   full_o         count == DEPTH
//   empty_o        count == 0
//   almost_full_o  count >= AF_THRESH
//   almost_empty_o count <= AE_THRESH
//   count_o        occupancy, 0..DEPTH
//   overflow_o     sticky: a write was rejected
//   underflow_o    sticky: a read was rejected
module fifo_param #(
    parameter int WIDTH        = 32,
    parameter int ENTRIES_POW2 = 3,
    parameter int FWFT         = 0,
    parameter int AF_THRESH    = (2 ** ENTRIES_POW2) - 1,
    parameter int AE_THRESH    = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    write_i,
    input  logic [WIDTH-1:0]        write_data_i,
    input  logic                    read_i,
    output logic [WIDTH-1:0]        read_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic [ENTRIES_POW2:0]   count_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int DEPTH = 2 ** ENTRIES_POW2;
    localparam int CW    = ENTRIES_POW2 + 1;
    localparam int PW    = ENTRIES_POW2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wptr_reg;
    logic [PW-1:0]    rptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             overflow_reg;
    logic             underflow_reg;
    logic [WIDTH-1:0] rdata_reg;

    logic             rd_acc;
    logic             wr_acc;
    logic             rd_en;
    logic             wr_en;

    // Acceptance is judged against the pre-edge state. A write into a full
    // FIFO goes through only when a read frees the head slot on the same edge.
    // Flush overrides both requests, so the enables are gated separately from
    // the acceptance terms that feed the error flags.
    always_comb begin
        rd_acc     = read_i & ~empty_o;
        wr_acc     = write_i & (~full_o | rd_acc);
        rd_en      = rd_acc & ~flush_i;
        wr_en      = wr_acc & ~flush_i;
        count_next = count_reg + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, rd_en};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            rdata_reg     <= '0;
        end else if (flush_i) begin
            // rdata_reg deliberately keeps the last delivered word.
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (rd_en) begin
                rptr_reg  <= rptr_reg + PTR_ONE;
                // Standard mode: this is the read data. FWFT mode: this
                // captures the popped head so it stays visible once empty.
                rdata_reg <= mem[rptr_reg];
            end
            count_reg <= count_next;
            if (write_i & ~wr_acc) begin
                overflow_reg <= 1'b1;
            end
            if (read_i & ~rd_acc) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // Storage carries no reset; its contents are meaningless until written.
    // On a write-through at full, wptr == rptr and the read above samples the
    // old word before this write lands.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr_reg] <= write_data_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign read_data_o = empty_o ? rdata_reg : mem[rptr_reg];
        end else begin : g_std
            assign read_data_o = rdata_reg;
        end
    endgenerate

    assign count_o        = count_reg;
    assign empty_o        = (count_reg == '0);
    assign full_o         = (count_reg == DEPTH_C);
    assign almost_full_o  = (count_reg >= AF_C);
    assign almost_empty_o = (count_reg <= AE_C);
    assign overflow_o     = overflow_reg;
    assign underflow_o    = underflow_reg;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param. Instance A is the default standard-read
// build (DEPTH=8, AF=7, AE=1) driven against a queue scoreboard; instance B is
// an FWFT build exercised with directed steps, including a mid-stream reset.
module tb_fifo_param;

    logic        clk;

    // Instance A: standard read
    logic        rst_a, flush_a, wr_a, rd_a;
    logic [31:0] wd_a, rdata_a;
    logic        full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [3:0]  count_a;

    // Instance B: first-word-fall-through
    logic        rst_b, flush_b, wr_b, rd_b;
    logic [31:0] wd_b, rdata_b;
    logic        full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [3:0]  count_b;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] sb[$];
    logic [31:0] exp_rdata;
    logic        exp_ovf, exp_udf;

    fifo_param #(.WIDTH(32), .ENTRIES_POW2(3), .FWFT(0), .AF_THRESH(7), .AE_THRESH(1)) u_std (
        .clk_i(clk), .reset_i(rst_a), .flush_i(flush_a),
        .write_i(wr_a), .write_data_i(wd_a), .read_i(rd_a), .read_data_o(rdata_a),
        .full_o(full_a), .empty_o(empty_a), .almost_full_o(af_a), .almost_empty_o(ae_a),
        .count_o(count_a), .overflow_o(ovf_a), .underflow_o(udf_a)
    );

    fifo_param #(.WIDTH(32), .ENTRIES_POW2(3), .FWFT(1), .AF_THRESH(7), .AE_THRESH(1)) u_fwft (
        .clk_i(clk), .reset_i(rst_b), .flush_i(flush_b),
        .write_i(wr_b), .write_data_i(wd_b), .read_i(rd_b), .read_data_o(rdata_b),
        .full_o(full_b), .empty_o(empty_b), .almost_full_o(af_b), .almost_empty_o(ae_b),
        .count_o(count_b), .overflow_o(ovf_b), .underflow_o(udf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full state comparison of instance A against the scoreboard model.
    task automatic check_a(input string tag);
        int sz;
        sz = sb.size();
        chk({tag, ".count"}, 32'(count_a), 32'(sz));
        chk({tag, ".rdata"}, rdata_a, exp_rdata);
        chk({tag, ".empty"}, 32'(empty_a), 32'(sz == 0));
        chk({tag, ".full"},  32'(full_a),  32'(sz == 8));
        chk({tag, ".afull"}, 32'(af_a),    32'(sz >= 7));
        chk({tag, ".aempty"}, 32'(ae_a),   32'(sz <= 1));
        chk({tag, ".ovf"},   32'(ovf_a),   32'(exp_ovf));
        chk({tag, ".udf"},   32'(udf_a),   32'(exp_udf));
    endtask

    // One clock of instance A. Acceptance is decided from the pre-edge model
    // state; the scoreboard is popped/pushed once the edge has happened.
    task automatic cyc_a(input string tag, input logic w, input logic [31:0] d,
                         input logic r, input logic f);
        logic ra, wa;
        wr_a = w; wd_a = d; rd_a = r; flush_a = f;
        ra = r && (sb.size() != 0);
        wa = w && ((sb.size() != 8) || ra);
        @(posedge clk);
        #1;
        wr_a = 1'b0; rd_a = 1'b0; flush_a = 1'b0;
        if (f) begin
            sb.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            if (ra) exp_rdata = sb.pop_front();
            if (wa) sb.push_back(d);
            if (r && !ra) exp_udf = 1'b1;
            if (w && !wa) exp_ovf = 1'b1;
        end
        $display("[A] %-10s w=%0d d=%0h r=%0d f=%0d -> count=%0d rdata=%0h ovf=%0d udf=%0d",
                 tag, w, d, r, f, count_a, rdata_a, ovf_a, udf_a);
        check_a(tag);
    endtask

    initial begin
        rst_a = 1'b1; flush_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; wd_a = '0;
        rst_b = 1'b1; flush_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; wd_b = '0;
        exp_rdata = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
        #23;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check_a("reset");

        // Read on empty
        cyc_a("rd_empty", 1'b0, 32'd0, 1'b1, 1'b0);

        // Fill 1..8, rejected 9th write, drain 8, extra read
        for (int i = 1; i <= 8; i++) cyc_a($sformatf("fill%0d", i), 1'b1, 32'(i), 1'b0, 1'b0);
        cyc_a("wr_full", 1'b1, 32'd9, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) cyc_a($sformatf("drain%0d", i), 1'b0, 32'd0, 1'b1, 1'b0);
        cyc_a("rd_extra", 1'b0, 32'd0, 1'b1, 1'b0);

        // Simultaneous read/write mid-range, then write-through at full
        for (int i = 1; i <= 3; i++) cyc_a($sformatf("w%0d", i), 1'b1, 32'(i), 1'b0, 1'b0);
        cyc_a("rw_mid", 1'b1, 32'd4, 1'b1, 1'b0);
        for (int i = 5; i <= 9; i++) cyc_a($sformatf("w%0d", i), 1'b1, 32'(i), 1'b0, 1'b0);
        cyc_a("rw_full", 1'b1, 32'd10, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc_a($sformatf("dr%0d", i), 1'b0, 32'd0, 1'b1, 1'b0);

        // Pointer wrap: 20 words with occupancy held at 3
        for (int i = 1; i <= 3; i++) cyc_a($sformatf("wrap_w%0d", i), 1'b1, 32'(100 + i), 1'b0, 1'b0);
        for (int i = 4; i <= 20; i++) cyc_a($sformatf("wrap_rw%0d", i), 1'b1, 32'(100 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc_a($sformatf("wrap_r%0d", i), 1'b0, 32'd0, 1'b1, 1'b0);

        // Flush at count 5 with read and write asserted
        for (int i = 1; i <= 5; i++) cyc_a($sformatf("pre_fl%0d", i), 1'b1, 32'(200 + i), 1'b0, 1'b0);
        cyc_a("flush", 1'b1, 32'hDEAD, 1'b1, 1'b1);
        cyc_a("post_w", 1'b1, 32'hA, 1'b0, 1'b0);
        cyc_a("post_r", 1'b0, 32'd0, 1'b1, 1'b0);

        // Read+write on empty: write only, underflow sets
        cyc_a("rw_empty", 1'b1, 32'hB, 1'b1, 1'b0);
        cyc_a("rd_b", 1'b0, 32'd0, 1'b1, 1'b0);

        // FWFT instance
        chk("fwft.reset.rdata", rdata_b, 32'd0);
        wr_b = 1'b1; wd_b = 32'h55;
        @(posedge clk); #1;
        wr_b = 1'b0;
        $display("[B] write 55 -> rdata=%0h empty=%0d count=%0d", rdata_b, empty_b, count_b);
        chk("fwft.w55.rdata", rdata_b, 32'h55);
        chk("fwft.w55.empty", 32'(empty_b), 32'd0);
        rd_b = 1'b1;
        @(posedge clk); #1;
        rd_b = 1'b0;
        $display("[B] pop -> rdata=%0h empty=%0d count=%0d", rdata_b, empty_b, count_b);
        chk("fwft.pop.empty", 32'(empty_b), 32'd1);
        chk("fwft.pop.rdata", rdata_b, 32'h55);
        for (int i = 1; i <= 4; i++) begin
            wr_b = 1'b1; wd_b = 32'(i);
            @(posedge clk); #1;
            wr_b = 1'b0;
            $display("[B] write %0h -> rdata=%0h count=%0d", i, rdata_b, count_b);
        end
        chk("fwft.w4.count", 32'(count_b), 32'd4);
        chk("fwft.w4.head", rdata_b, 32'd1);
        #2;
        rst_b = 1'b1;
        #1;
        $display("[B] async reset -> count=%0d empty=%0d rdata=%0h", count_b, empty_b, rdata_b);
        chk("fwft.arst.count", 32'(count_b), 32'd0);
        chk("fwft.arst.empty", 32'(empty_b), 32'd1);
        chk("fwft.arst.rdata", rdata_b, 32'd0);
        #1;
        rst_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
